// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 4-digit 7-segment scanner.
// Segment codes are active-low, bit0=a .. bit6=g; anode vectors are active-low.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   typedef logic [1:0] dig_idx_t;

   // One anode low, the rest high.
   function automatic logic [3:0] an_sel(input dig_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

   function automatic logic [3:0] nibble(input logic [15:0] v,
                                         input dig_idx_t   idx);
      return v[{idx, 2'b00} +: 4];
   endfunction

   // True when every nibble from idx upward is zero, i.e. the digit
   // is a leading zero. Digit 0 is never a leading zero.
   function automatic logic lz_hidden(input logic [15:0] v,
                                      input dig_idx_t   idx);
      logic h;
      h = 1'b0;
      unique case (idx)
         2'd0: h = 1'b0;
         2'd1: h = (v[15:4] == 12'h000);
         2'd2: h = (v[15:8] == 8'h00);
         2'd3: h = (v[15:12] == 4'h0);
      endcase
      return h;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment code.
// Ports: hex_i (4-bit value), seg_o (7-bit segments, bit0=a .. bit6=g).
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      unique case (hex_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit hex display scanner with ghost blanking,
// leading-zero suppression and a frame-synchronous double-buffered load.
// Ports: Clock, Reset (async active-low); load_valid/load_data/load_ready
// handshake into the pending buffer; lz_blank, disp_en controls;
// out7 (segments), en_out (anodes), both active-low and registered;
// frame_tick pulses for one cycle after each frame wrap.
module seg_scan_ctrl #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLANK_CYC   = 1000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   input  logic        lz_blank,
   input  logic        disp_en,
   output logic [6:0]  out7,
   output logic [3:0]  en_out,
   output logic        frame_tick
);

   import seg_pkg::*;

   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] BLANK_N = PW'(BLANK_CYC);

   logic [PW-1:0] presc_q, presc_d;
   dig_idx_t      idx_q,   idx_d;
   logic [15:0]   disp_q,  disp_d;
   logic [15:0]   pend_q,  pend_d;
   logic          pend_v_q, pend_v_d;
   logic          ready_q, ready_d;
   logic [6:0]    out7_q,  out7_d;
   logic [3:0]    en_q,    en_d;
   logic          tick_q,  tick_d;

   logic          slot_end;
   logic          frame_wrap;
   logic          blank_all;
   logic          hide;
   logic          accept;
   logic [3:0]    nib;
   logic [6:0]    seg_hex;

   assign slot_end   = (presc_q == PS_LAST);
   assign frame_wrap = disp_en && slot_end && (idx_q == 2'd3);
   assign blank_all  = !disp_en || (presc_q < BLANK_N);
   assign hide       = lz_blank && lz_hidden(disp_q, idx_q);
   assign accept     = load_valid && ready_q;
   assign nib        = nibble(disp_q, idx_q);

   seg_hex_decode u_dec (
      .hex_i (nib),
      .seg_o (seg_hex)
   );

   // Scan position; frozen while the display is disabled.
   always_comb begin
      presc_d = presc_q;
      idx_d   = idx_q;
      if (disp_en) begin
         presc_d = slot_end ? '0 : presc_q + 1'b1;
         if (slot_end) begin
            idx_d = idx_q + 2'd1;
         end
      end
   end

   // Double buffer. A commit only happens when something is pending,
   // so an accept landing on the wrap edge waits for the next wrap.
   always_comb begin
      disp_d   = disp_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      if (frame_wrap && pend_v_q) begin
         disp_d   = pend_q;
         pend_v_d = 1'b0;
      end
      if (accept) begin
         pend_d   = load_data;
         pend_v_d = 1'b1;
      end
      ready_d = !pend_v_d;
   end

   always_comb begin
      out7_d = SEG_BLANK;
      en_d   = AN_OFF;
      priority case (1'b1)
         blank_all: begin
            out7_d = SEG_BLANK;
            en_d   = AN_OFF;
         end
         hide: begin
            out7_d = SEG_BLANK;
            en_d   = an_sel(idx_q);
         end
         default: begin
            out7_d = seg_hex;
            en_d   = an_sel(idx_q);
         end
      endcase
      tick_d = frame_wrap;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         presc_q  <= '0;
         idx_q    <= 2'd0;
         disp_q   <= 16'h0000;
         pend_q   <= 16'h0000;
         pend_v_q <= 1'b0;
         ready_q  <= 1'b1;
         out7_q   <= SEG_BLANK;
         en_q     <= AN_OFF;
         tick_q   <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         ready_q  <= ready_d;
         out7_q   <= out7_d;
         en_q     <= en_d;
         tick_q   <= tick_d;
      end
   end

   assign load_ready = ready_q;
   assign out7       = out7_q;
   assign en_out     = en_q;
   assign frame_tick = tick_q;

endmodule
